countn_updown: RTL and testbench
================================

// Module: countn_updown
// PURPOSE
// - Parametrised modulo-N up/down counter; next generation of the fixed 0..6 counter.
// - Adds: modulus/width generics, count enable, direction, sync clear/load,
//   cascade terminal-count output, one-shot mode with DONE state.
// - Used standalone as a lab timebase or chained (TC -> en of next stage) for wide counts.
// PARAMETERS
// - MOD      7  counting modulus; CNT range 0..MOD-1; legal 2..2**WIDTH
// - WIDTH    3  width of CNT / load_val
// - ONESHOT  0  0 = wrap continuously; 1 = stop at terminal value, hold DONE
// - WRAP_W   8  width of WRAPS (only with COUNTN_WRAPCNT_EN)
// PORTS
// - clk       in   1      rising-edge clock
// - rst       in   1      asynchronous reset, active-high
// - en        in   1      count enable (one step per clk when high)
// - up        in   1      direction: 1 = up, 0 = down
// - clr       in   1      synchronous clear to 0, leave DONE
// - load      in   1      synchronous load of load_val, leave DONE
// - load_val  in   WIDTH  load value; >= MOD clamps to MOD-1
// - CNT       out  WIDTH  registered count
// - TC        out  1      comb: en & CNT at terminal (MOD-1 if up, 0 if down) & state RUN
// - WRAP      out  1      registered 1-cycle pulse, cycle after CNT wrapped
// - DONE      out  1      registered; ONESHOT=1 only, high in state DONE; tied 0 otherwise
// - WRAPS     out  WRAP_W saturating wrap count (only with COUNTN_WRAPCNT_EN)
// BEHAVIOUR
// - Reset (async, rst=1): CNT=0, WRAP=0, DONE=0, WRAPS=0, state RUN; TC=0 while rst.
// - Priority each edge: clr > load > en; clr and load ignore en and direction.
// - Up: CNT=MOD-1 -> 0 (wrap); else CNT+1. Down: CNT=0 -> MOD-1 (wrap); else CNT-1.
// - Arithmetic in WIDTH+1 bits; CNT never leaves 0..MOD-1, incl. MOD=2**WIDTH.
// - Direction change mid-count takes effect on the next enabled edge, no bubble.
// - en=0: CNT, state hold; WRAP=0 next cycle.
// - WRAP=1 exactly one cycle after each wrap edge; never on clr/load.
// - FSM (ONESHOT=1): RUN --(en & at terminal)--> DONE; CNT takes the wrapped value
//   (0 up / MOD-1 down), WRAP pulses; DONE: CNT holds, en ignored, TC=0;
//   DONE --clr--> RUN (CNT=0); DONE --load--> RUN (CNT=load_val clamped).
// - ONESHOT=0: FSM fixed in RUN, DONE constant 0.
// - Load of terminal value with en held: TC high the following cycle, wrap on the next edge.
// - rst asserted mid-count or in DONE: immediate return to reset values.
// - Latency: CNT updates one clk after the controlling input is sampled.
// CONFIGURATION
// - COUNTN_WRAPCNT_EN defined: WRAPS port present; +1 per wrap, saturates at
//   2**WRAP_W-1; cleared by rst and clr, unaffected by load.
// - COUNTN_WRAPCNT_EN undefined: WRAPS port and its logic absent; all else identical.
// TESTING
// - rst=1 100ns then en=1 up=1, MOD=7: CNT 0,1..6,0; TC high at CNT=6; WRAP 1 cycle after 6->0.
// - up=0 from CNT=0: CNT 6,5..0,6; TC high at CNT=0; WRAP after each 0->6.
// - load=1 load_val=5 then 7 (MOD=7): CNT=5, then CNT=6 (clamped); clr+load same edge -> CNT=0.
// - ONESHOT=1 up: CNT reaches 6, next edge CNT=0, DONE=1, CNT holds with en=1; clr -> RUN, DONE=0.
// - MOD=8 WIDTH=3: 7->0 wrap, no X/overflow; rst pulse at CNT=4 mid-cycle -> CNT=0 immediately.
// - COUNTN_WRAPCNT_EN, WRAP_W=2: 5 wraps -> WRAPS=3 (saturated); clr -> WRAPS=0.

Source files
------------

// File: rtl/countn_updown.sv
// ---------------------------------------------------------------------------
// countn_updown
//
// Parametrised modulo-MOD up/down counter with count enable, synchronous
// clear and load, a combinational terminal-count output for cascading, a
// registered wrap pulse, and an optional one-shot mode that stops at the
// terminal value and holds a DONE state until cleared or loaded.
//
// Parameters
//   counting modulus MOD: CNT ranges 0..MOD-1 (legal 2..2**WIDTH)
//   WIDTH    width of CNT and load_val
//   ONESHOT  0 = wrap continuously, 1 = stop after the wrap edge in DONE
//   WRAP_W   width of WRAPS (only meaningful with COUNTN_WRAPCNT_EN)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   en        in   count enable, one step per clock when high
//   up        in   direction, 1 = up, 0 = down
//   clr       in   synchronous clear to 0 (also leaves DONE)
//   load      in   synchronous load of load_val (also leaves DONE)
//   load_val  in   load value, values >= MOD clamp to MOD-1
//   CNT       out  registered count
//   TC        out  combinational terminal count: en & CNT at terminal & RUN
//   WRAP      out  registered one-cycle pulse, the cycle after CNT wrapped
//   DONE      out  registered, high in the DONE state (ONESHOT=1 only)
//   WRAPS     out  saturating wrap counter (only with COUNTN_WRAPCNT_EN)
//
// Build option
//   COUNTN_WRAPCNT_EN  when defined, adds the WRAPS port and its counter.
//                      WRAPS is cleared by rst and clr, unaffected by load.
// ---------------------------------------------------------------------------
module countn_updown #(
    parameter int MOD     = 7,
    parameter int WIDTH   = 3,
    parameter int ONESHOT = 0,
    parameter int WRAP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             WRAP,
    output logic             DONE
`ifdef COUNTN_WRAPCNT_EN
    ,
    output logic [WRAP_W-1:0] WRAPS
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Modulus held in WIDTH+1 bits so MOD = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MOD - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt_next;
    logic             wrap_event;

    logic [WIDTH:0]   cnt_inc;
    logic             at_top;
    logic             at_bot;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    // Terminal detection. The increment is done one bit wider so that the
    // top value MOD-1 = 2**WIDTH-1 is detected without overflow.
    always_comb begin
        cnt_inc = {1'b0, CNT} + (WIDTH+1)'(1);
        at_top  = (cnt_inc == MOD_W);
        at_bot  = (CNT == '0);
        at_term = up ? at_top : at_bot;
    end

    // Out-of-range load values saturate to the top of the count range.
    always_comb begin
        if ({1'b0, load_val} >= MOD_W)
            load_clamped = TERM_UP;
        else
            load_clamped = load_val;
    end

    // TC is gated by rst because the reset value 0 is the down terminal.
    assign TC = ~rst & en & at_term & (state == ST_RUN);

    // Next-state logic. Priority: clr > load > en.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        cnt_next   = CNT;
        state_next = state;
        wrap_event = 1'b0;

        if (clr) begin
            cnt_next   = '0;
            state_next = ST_RUN;
        end else if (load) begin
            cnt_next   = load_clamped;
            state_next = ST_RUN;
        end else if (en && (state == ST_RUN)) begin
            wrap_event = at_term;
            if (up)
                cnt_next = at_top ? '0 : cnt_inc[WIDTH-1:0];
            else
                cnt_next = at_bot ? TERM_UP : (CNT - WIDTH'(1));
            // One-shot: the wrapping edge still takes the wrapped value,
            // then the counter parks in DONE.
            if (at_term && (ONESHOT != 0))
                state_next = ST_DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            CNT   <= '0;
            WRAP  <= 1'b0;
        end else begin
            state <= state_next;
            CNT   <= cnt_next;
            WRAP  <= wrap_event;
        end
    end

    assign DONE = (ONESHOT != 0) && (state == ST_DONE);

`ifdef COUNTN_WRAPCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            WRAPS <= '0;
        else if (clr)
            WRAPS <= '0;
        else if (wrap_event && (WRAPS != '1))
            WRAPS <= WRAPS + WRAP_W'(1);
    end
`endif

endmodule

// File: tb/tb_countn_updown.sv
// ---------------------------------------------------------------------------
// tb_countn_updown
//
// Drives three countn_updown instances from shared inputs:
//   index 0: MOD=7 WIDTH=3 continuous
//   index 1: MOD=8 WIDTH=3 continuous (full binary range)
//   index 2: MOD=7 WIDTH=3 one-shot
// A modular-arithmetic reference model predicts every output. A vector
// table exercises the MOD=7 counter, hand sequences cover one-shot, the
// wrap of the MOD=8 counter, async reset mid-cycle and (when built with
// the option) saturating WRAPS; a random phase follows.
// ---------------------------------------------------------------------------
module tb_countn_updown;

    localparam int N = 3;
    localparam int WW = 2;
    localparam int MODS [N] = '{7, 8, 7};
    localparam bit ONES [N] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst, en, up, clr, load;
    logic [2:0] load_val;

    logic [2:0]    cnt_o  [N];
    logic [N-1:0]  tc_o;
    logic [N-1:0]  wrap_o;
    logic [N-1:0]  done_o;
    logic [WW-1:0] wraps_o [N];

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    int m_cnt   [N];
    bit m_done  [N];
    bit m_wrap  [N];
    int m_wraps [N];

    always #5 clk = ~clk;

    countn_updown #(.MOD(7), .WIDTH(3), .ONESHOT(0), .WRAP_W(WW)) u_mod7 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .CNT(cnt_o[0]), .TC(tc_o[0]), .WRAP(wrap_o[0]),
        .DONE(done_o[0])
`ifdef COUNTN_WRAPCNT_EN
        , .WRAPS(wraps_o[0])
`endif
    );

    countn_updown #(.MOD(8), .WIDTH(3), .ONESHOT(0), .WRAP_W(WW)) u_mod8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .CNT(cnt_o[1]), .TC(tc_o[1]), .WRAP(wrap_o[1]),
        .DONE(done_o[1])
`ifdef COUNTN_WRAPCNT_EN
        , .WRAPS(wraps_o[1])
`endif
    );

    countn_updown #(.MOD(7), .WIDTH(3), .ONESHOT(1), .WRAP_W(WW)) u_shot (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .CNT(cnt_o[2]), .TC(tc_o[2]), .WRAP(wrap_o[2]),
        .DONE(done_o[2])
`ifdef COUNTN_WRAPCNT_EN
        , .WRAPS(wraps_o[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_tc(input int i);
        if (rst || !en || m_done[i]) return 1'b0;
        return up ? (m_cnt[i] == MODS[i] - 1) : (m_cnt[i] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_done[i] = 0; m_wrap[i] = 0; m_wraps[i] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, using sampled inputs.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit wrapped;
            wrapped = 0;
            if (clr) begin
                m_cnt[i] = 0; m_done[i] = 0; m_wraps[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) >= MODS[i]) ? MODS[i] - 1 : int'(load_val);
                m_done[i] = 0;
            end else if (en && !m_done[i]) begin
                if (up) begin
                    wrapped = (m_cnt[i] == MODS[i] - 1);
                    m_cnt[i] = (m_cnt[i] + 1) % MODS[i];
                end else begin
                    wrapped = (m_cnt[i] == 0);
                    m_cnt[i] = (m_cnt[i] + MODS[i] - 1) % MODS[i];
                end
                if (wrapped) begin
                    if (m_wraps[i] < (1 << WW) - 1) m_wraps[i]++;
                    if (ONES[i]) m_done[i] = 1;
                end
            end
            m_wrap[i] = wrapped;
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s cnt[%0d]", tag, i), 32'(cnt_o[i]), 32'(m_cnt[i]));
            check($sformatf("%s wrap[%0d]", tag, i), 32'(wrap_o[i]), 32'(m_wrap[i]));
            check($sformatf("%s done[%0d]", tag, i), 32'(done_o[i]), 32'(m_done[i]));
`ifdef COUNTN_WRAPCNT_EN
            check($sformatf("%s wraps[%0d]", tag, i), 32'(wraps_o[i]), 32'(m_wraps[i]));
`endif
        end
    endtask

    // Drive inputs at negedge, check TC before the edge, step the model
    // at the edge and check registered outputs 1 ns after it.
    task automatic cycle(input logic e, input logic u, input logic c, input logic l,
                         input logic [2:0] v, output logic [N-1:0] tc_seen);
        @(negedge clk);
        en = e; up = u; clr = c; load = l; load_val = v;
        #1;
        tc_seen = tc_o;
        for (int i = 0; i < N; i++)
            check($sformatf("tc[%0d]", i), 32'(tc_o[i]), 32'(model_tc(i)));
        @(posedge clk);
        model_step();
        #1;
        check_state("step");
    endtask

    // Reset pulse entirely between clock edges, with en=1 up=0 so the
    // reset value 0 would otherwise look like a terminal count.
    task automatic rst_pulse();
        @(negedge clk);
        en = 1; up = 0; clr = 0; load = 0;
        #2 rst = 1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("async cnt[%0d]", i), 32'(cnt_o[i]), 32'd0);
            check($sformatf("async tc[%0d]", i), 32'(tc_o[i]), 32'd0);
            check($sformatf("async done[%0d]", i), 32'(done_o[i]), 32'd0);
            check($sformatf("async wrap[%0d]", i), 32'(wrap_o[i]), 32'd0);
        end
        #1 rst = 0; en = 0;
        model_reset();
    endtask

    typedef struct {
        logic       en, up, clr, load;
        logic [2:0] lv;
        logic       tc;
        logic [2:0] cnt;
        logic       wrap;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic u, input logic c, input logic l,
                                input logic [2:0] v, input logic t, input logic [2:0] n,
                                input logic w);
        vec_t r;
        r.en = e; r.up = u; r.clr = c; r.load = l; r.lv = v;
        r.tc = t; r.cnt = n; r.wrap = w;
        return r;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs [21];
        logic [N-1:0] tcs;

        // Expected MOD=7 sequence from reset (TC before edge, CNT/WRAP after)
        vecs[0]  = mk(1,1,0,0,0, 0,1,0);
        vecs[1]  = mk(1,1,0,0,0, 0,2,0);
        vecs[2]  = mk(1,1,0,0,0, 0,3,0);
        vecs[3]  = mk(1,1,0,0,0, 0,4,0);
        vecs[4]  = mk(1,1,0,0,0, 0,5,0);
        vecs[5]  = mk(1,1,0,0,0, 0,6,0);
        vecs[6]  = mk(1,1,0,0,0, 1,0,1);   // 6 -> 0 wrap
        vecs[7]  = mk(1,0,0,0,0, 1,6,1);   // down from 0 wraps to 6
        vecs[8]  = mk(1,0,0,0,0, 0,5,0);
        vecs[9]  = mk(0,0,0,0,0, 0,5,0);   // hold
        vecs[10] = mk(0,0,0,1,2, 0,2,0);   // load ignores en
        vecs[11] = mk(1,1,0,1,7, 0,6,0);   // load 7 clamps to 6
        vecs[12] = mk(1,1,0,0,0, 1,0,1);   // loaded terminal: TC then wrap
        vecs[13] = mk(1,1,1,1,5, 0,0,0);   // clr beats load
        vecs[14] = mk(1,1,0,1,5, 0,5,0);
        vecs[15] = mk(1,0,0,0,0, 0,4,0);
        vecs[16] = mk(1,1,0,0,0, 0,5,0);   // direction change, no bubble
        vecs[17] = mk(1,0,1,0,0, 0,0,0);
        vecs[18] = mk(1,0,1,0,0, 1,0,0);   // clr at terminal: no wrap
        vecs[19] = mk(1,0,0,0,0, 1,6,1);
        vecs[20] = mk(0,1,0,0,0, 0,6,0);   // en=0 drops WRAP

        rst = 1; en = 1; up = 0; clr = 0; load = 0; load_val = 0;
        model_reset();
        #50;
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset cnt[%0d]", i), 32'(cnt_o[i]), 32'd0);
            check($sformatf("reset tc[%0d]", i), 32'(tc_o[i]), 32'd0);
            check($sformatf("reset wrap[%0d]", i), 32'(wrap_o[i]), 32'd0);
            check($sformatf("reset done[%0d]", i), 32'(done_o[i]), 32'd0);
        end
        #48 en = 0; up = 1;
        #2 rst = 0;

        for (int k = 0; k < 21; k++) begin
            cycle(vecs[k].en, vecs[k].up, vecs[k].clr, vecs[k].load, vecs[k].lv, tcs);
            check($sformatf("vec%0d tc", k), 32'(tcs[0]), 32'(vecs[k].tc));
            check($sformatf("vec%0d cnt", k), 32'(cnt_o[0]), 32'(vecs[k].cnt));
            check($sformatf("vec%0d wrap", k), 32'(wrap_o[0]), 32'(vecs[k].wrap));
        end

        // One-shot: run to 6, wrap into DONE, hold with en=1, clr back to RUN
        cycle(0,1,1,0,0, tcs);
        repeat (6) cycle(1,1,0,0,0, tcs);
        check("shot at6 cnt", 32'(cnt_o[2]), 32'd6);
        cycle(1,1,0,0,0, tcs);
        check("shot tc before wrap", 32'(tcs[2]), 32'd1);
        check("shot wrap cnt", 32'(cnt_o[2]), 32'd0);
        check("shot done set", 32'(done_o[2]), 32'd1);
        check("shot wrap pulse", 32'(wrap_o[2]), 32'd1);
        cycle(1,0,0,0,0, tcs);
        check("shot tc in done", 32'(tcs[2]), 32'd0);
        check("shot hold cnt", 32'(cnt_o[2]), 32'd0);
        check("shot hold done", 32'(done_o[2]), 32'd1);
        cycle(1,0,1,0,0, tcs);
        check("shot clr done", 32'(done_o[2]), 32'd0);
        // One-shot down: load 0 then step down into DONE at MOD-1
        cycle(0,0,0,1,0, tcs);
        cycle(1,0,0,0,0, tcs);
        check("shot down cnt", 32'(cnt_o[2]), 32'd6);
        check("shot down done", 32'(done_o[2]), 32'd1);
        cycle(0,0,0,1,3, tcs);
        check("shot load leaves done", 32'(done_o[2]), 32'd0);
        check("shot load cnt", 32'(cnt_o[2]), 32'd3);

        // Full binary range counter: wrap 7 -> 0, then async reset at CNT=4
        cycle(0,1,1,0,0, tcs);
        cycle(0,1,0,1,7, tcs);
        check("mod8 load7", 32'(cnt_o[1]), 32'd7);
        cycle(1,1,0,0,0, tcs);
        check("mod8 tc at7", 32'(tcs[1]), 32'd1);
        check("mod8 wrap cnt", 32'(cnt_o[1]), 32'd0);
        check("mod8 wrap pulse", 32'(wrap_o[1]), 32'd1);
        repeat (4) cycle(1,1,0,0,0, tcs);
        check("mod8 at4", 32'(cnt_o[1]), 32'd4);
        rst_pulse();

`ifdef COUNTN_WRAPCNT_EN
        // Five wraps saturate a 2-bit WRAPS at 3; load leaves it, clr clears
        cycle(0,1,1,0,0, tcs);
        repeat (5) begin
            cycle(0,1,0,1,6, tcs);
            cycle(1,1,0,0,0, tcs);
        end
        check("wraps saturated", 32'(wraps_o[0]), 32'd3);
        cycle(0,1,0,1,2, tcs);
        check("wraps after load", 32'(wraps_o[0]), 32'd3);
        cycle(0,1,1,0,0, tcs);
        check("wraps cleared", 32'(wraps_o[0]), 32'd0);
`endif

        // Random phase against the model, with occasional async resets
        for (int k = 0; k < 400; k++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            cycle(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0,
                  ($urandom % 12) == 0, v, tcs);
            if ((k % 100) == 99) rst_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
